sequencer: RTL and testbench
============================

SEQUENCER -- requirements
Module: sequencer

Interface
REQ-001 SHALL have no parameters; the state width is fixed at 8 bits, with codes from the `STATE_* defines in symbols.vh.
REQ-002 SHALL have port: clk  input  1  single clock, all state changes on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high; clears all registers immediately.
REQ-004 SHALL have port: instr  input  8  instruction register contents; [7:6] class, [5:3] op1, [2:0] op2.
REQ-005 SHALL have port: hold  input  1  stall request (memory busy); freezes the sequencer.
REQ-006 SHALL have port: step_mode  input  1  when 1, pause before each instruction fetch.
REQ-007 SHALL have port: step  input  1  single-cycle pulse that releases one paused instruction.
REQ-008 SHALL have port: state  output  8  current state code, drives the control decoder.
REQ-009 SHALL have port: operand1 / operand2  output  3 each  op1/op2 latched at DECODE.
REQ-010 SHALL have port: instr_done  output  1  one-cycle pulse in the last state of each instruction.
REQ-011 SHALL have port: halted  output  1  high while in STATE_HALT.
REQ-012 SHALL have port: illegal  output  1  sticky; set by an undefined encoding.

Function
REQ-013 SHALL run the fetch sequence FETCH_PC -> FETCH_INST -> DECODE, one state per cycle.
REQ-014 SHALL latch operand1/operand2 from instr during DECODE and hold them until the next DECODE.
REQ-015 SHALL, for class 00 (ALU), sequence ALU_EXEC -> ALU_OUT.
REQ-016 SHALL, for class 01 (MOV), sequence MOV_REG.
REQ-017 SHALL, for class 10, decode op2 as follows:
- 000 LDI: FETCH_PC -> SET_REG
- 001 LD: FETCH_PC -> LOAD_ADDR -> SET_REG
- 010 ST: FETCH_PC -> LOAD_ADDR -> SET_MEM
- 011 PUSH: FETCH_SP -> STACK_REG
- 100 POP: INC_SP -> FETCH_SP -> SET_REG
- others: illegal
REQ-018 SHALL, for class 11, decode op1 as follows:
- 000 jump family: FETCH_PC -> SET_MAR -> JUMP, for all op2 conditions
- 001 CALL: FETCH_PC -> SET_MAR -> FETCH_SP -> STORE_PC -> TMP_JUMP
- 010 RET: INC_SP -> FETCH_SP -> RET
- 011 NOP: no execute states
- 111 HALT: HALT
- others: illegal
REQ-019 SHALL evaluate jump conditions outside this block; the sequencer always visits JUMP.
REQ-020 SHALL assert instr_done in the final execute state; for NOP, in DECODE.
REQ-021 SHALL, after the final state, enter FETCH_PC when step_mode=0, else STATE_WAIT.
REQ-022 SHALL leave STATE_WAIT for FETCH_PC in the cycle after step=1; step pulses outside WAIT are ignored.
REQ-023 SHALL, while hold=1, keep state, operands and flags unchanged, and suppress instr_done for the held cycle (instr_done re-asserts once hold drops).
REQ-024 SHALL give hold priority over step when both are asserted in WAIT.
REQ-025 SHALL, on an illegal encoding, set illegal and go DECODE -> HALT.
REQ-026 SHALL treat HALT as absorbing until reset; hold, step and instr are ignored there.
REQ-027 SHALL assert halted combinationally from state==STATE_HALT.

Reset
REQ-028 SHALL, on reset=1, asynchronously set state=STATE_FETCH_PC, operand1=0, operand2=0, instr_done=0, illegal=0.
REQ-029 SHALL, on reset mid-instruction, abandon the instruction with no completion pulse.
REQ-030 SHALL start fetching on the first clock edge after reset deasserts, regardless of step_mode.

Structure
REQ-031 SHALL place new state codes STATE_DECODE and STATE_WAIT in symbols.vh, distinct from all existing codes.
REQ-032 SHALL place class codes (CLS_ALU, CLS_MOV, CLS_MEM, CLS_CTL) and subop codes in symbols.vh.
REQ-033 SHALL implement encoding-to-sequence mapping in one combinational sub-module, seq_decode, which outputs the first execute state and an illegal flag.
REQ-034 SHALL implement next-state logic in sequencer as a single registered state plus next-state case.

Verification
REQ-035 SHALL cover: reset, then instr=8'b00_001_010 -> states FETCH_PC, FETCH_INST, DECODE, ALU_EXEC, ALU_OUT, FETCH_PC; operand1=1, operand2=2; instr_done in ALU_OUT.
REQ-036 SHALL cover: CALL instr=8'b11_001_000 with hold=1 during FETCH_SP for 3 cycles -> FETCH_SP held 4 cycles total; then STORE_PC, TMP_JUMP; exactly one instr_done.
REQ-037 SHALL cover: step_mode=1, MOV 8'b01_011_100 -> MOV_REG then WAIT persists 10 cycles; step pulse -> FETCH_PC next cycle.
REQ-038 SHALL cover: instr=8'b10_000_111 -> DECODE then HALT; illegal=1, halted=1; step and hold thereafter leave state=HALT.
REQ-039 SHALL cover: reset asserted mid-POP (in FETCH_SP) -> state=FETCH_PC immediately, no instr_done, illegal=0.

Source files
------------

// File: rtl/sequencer_pkg.sv
// State codes, instruction class/subop encodings and decoded instruction kinds
// shared by the sequencer and its decoder.
package sequencer_pkg;

    localparam logic [7:0] STATE_FETCH_PC   = 8'h01;
    localparam logic [7:0] STATE_FETCH_INST = 8'h02;
    localparam logic [7:0] STATE_DECODE     = 8'h03;
    localparam logic [7:0] STATE_ALU_EXEC   = 8'h04;
    localparam logic [7:0] STATE_ALU_OUT    = 8'h05;
    localparam logic [7:0] STATE_MOV_REG    = 8'h06;
    localparam logic [7:0] STATE_SET_REG    = 8'h07;
    localparam logic [7:0] STATE_LOAD_ADDR  = 8'h08;
    localparam logic [7:0] STATE_SET_MEM    = 8'h09;
    localparam logic [7:0] STATE_FETCH_SP   = 8'h0A;
    localparam logic [7:0] STATE_STACK_REG  = 8'h0B;
    localparam logic [7:0] STATE_INC_SP     = 8'h0C;
    localparam logic [7:0] STATE_SET_MAR    = 8'h0D;
    localparam logic [7:0] STATE_JUMP       = 8'h0E;
    localparam logic [7:0] STATE_STORE_PC   = 8'h0F;
    localparam logic [7:0] STATE_TMP_JUMP   = 8'h10;
    localparam logic [7:0] STATE_RET        = 8'h11;
    localparam logic [7:0] STATE_HALT       = 8'h12;
    localparam logic [7:0] STATE_WAIT       = 8'h13;

    localparam logic [1:0] CLS_ALU = 2'b00;
    localparam logic [1:0] CLS_MOV = 2'b01;
    localparam logic [1:0] CLS_MEM = 2'b10;
    localparam logic [1:0] CLS_CTL = 2'b11;

    // Memory-class subops live in op2, control-class subops in op1.
    localparam logic [2:0] MEM_LDI  = 3'b000;
    localparam logic [2:0] MEM_LD   = 3'b001;
    localparam logic [2:0] MEM_ST   = 3'b010;
    localparam logic [2:0] MEM_PUSH = 3'b011;
    localparam logic [2:0] MEM_POP  = 3'b100;
    localparam logic [2:0] CTL_JMP  = 3'b000;
    localparam logic [2:0] CTL_CALL = 3'b001;
    localparam logic [2:0] CTL_RET  = 3'b010;
    localparam logic [2:0] CTL_NOP  = 3'b011;
    localparam logic [2:0] CTL_HALT = 3'b111;

    typedef enum logic [3:0] {
        OP_ALU, OP_MOV, OP_LDI, OP_LD, OP_ST, OP_PUSH, OP_POP,
        OP_JMP, OP_CALL, OP_RET, OP_NOP, OP_HALT
    } op_kind_e;

endpackage

// File: rtl/sequencer_decode.sv
// Combinational instruction decoder: maps an encoding to its instruction kind,
// the first execute state, and an illegal-encoding flag.
module seq_decode
    import sequencer_pkg::*;
(
    input  logic [7:0] i_instr,
    output logic [7:0] o_first,
    output logic [3:0] o_kind,
    output logic       o_illegal
);

    always_comb begin
        o_first   = STATE_HALT;
        o_kind    = OP_HALT;
        o_illegal = 1'b0;
        case (i_instr[7:6])
            CLS_ALU: begin o_first = STATE_ALU_EXEC; o_kind = OP_ALU; end
            CLS_MOV: begin o_first = STATE_MOV_REG;  o_kind = OP_MOV; end
            CLS_MEM: begin
                case (i_instr[2:0])
                    MEM_LDI:  begin o_first = STATE_FETCH_PC; o_kind = OP_LDI;  end
                    MEM_LD:   begin o_first = STATE_FETCH_PC; o_kind = OP_LD;   end
                    MEM_ST:   begin o_first = STATE_FETCH_PC; o_kind = OP_ST;   end
                    MEM_PUSH: begin o_first = STATE_FETCH_SP; o_kind = OP_PUSH; end
                    MEM_POP:  begin o_first = STATE_INC_SP;   o_kind = OP_POP;  end
                    default:  o_illegal = 1'b1;
                endcase
            end
            default: begin
                case (i_instr[5:3])
                    CTL_JMP:  begin o_first = STATE_FETCH_PC; o_kind = OP_JMP;  end
                    CTL_CALL: begin o_first = STATE_FETCH_PC; o_kind = OP_CALL; end
                    CTL_RET:  begin o_first = STATE_INC_SP;   o_kind = OP_RET;  end
                    CTL_NOP:  begin o_first = STATE_FETCH_PC; o_kind = OP_NOP;  end
                    CTL_HALT: begin o_first = STATE_HALT;     o_kind = OP_HALT; end
                    default:  o_illegal = 1'b1;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/sequencer.sv
// Instruction sequencer: fetch/decode/execute state machine with stall (hold),
// single-step pausing and a sticky illegal-encoding halt.
module sequencer
    import sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] instr,
    input  logic       hold,
    input  logic       step_mode,
    input  logic       step,
    output logic [7:0] state,
    output logic [2:0] operand1,
    output logic [2:0] operand2,
    output logic       instr_done,
    output logic       halted,
    output logic       illegal
);

    logic [7:0] r_state;
    op_kind_e   r_op;
    logic       r_exec;
    logic [2:0] r_op1;
    logic [2:0] r_op2;
    logic       r_illegal;

    logic [7:0] w_first;
    logic [3:0] w_kind;
    logic       w_dec_illegal;
    logic [7:0] w_next;
    logic       w_exec_next;
    logic       w_last;

    seq_decode u_decode (
        .i_instr   (instr),
        .o_first   (w_first),
        .o_kind    (w_kind),
        .o_illegal (w_dec_illegal)
    );

    // r_exec separates FETCH_PC as an execute step (LDI/LD/ST/JMP/CALL) from
    // FETCH_PC as the start of the fetch sequence.
    always_comb begin
        w_next      = r_state;
        w_exec_next = r_exec;
        w_last      = 1'b0;
        case (r_state)
            STATE_FETCH_PC: begin
                if (!r_exec) begin
                    w_next = STATE_FETCH_INST;
                end else begin
                    case (r_op)
                        OP_LDI:       w_next = STATE_SET_REG;
                        OP_LD, OP_ST: w_next = STATE_LOAD_ADDR;
                        default:      w_next = STATE_SET_MAR;
                    endcase
                end
            end
            STATE_FETCH_INST: w_next = STATE_DECODE;
            STATE_DECODE: begin
                if (w_dec_illegal) begin
                    w_next = STATE_HALT;
                end else if (w_kind == OP_NOP) begin
                    w_last = 1'b1;
                end else begin
                    w_next      = w_first;
                    w_exec_next = 1'b1;
                end
            end
            STATE_ALU_EXEC:  w_next = STATE_ALU_OUT;
            STATE_LOAD_ADDR: w_next = (r_op == OP_ST) ? STATE_SET_MEM : STATE_SET_REG;
            STATE_SET_MAR:   w_next = (r_op == OP_CALL) ? STATE_FETCH_SP : STATE_JUMP;
            STATE_FETCH_SP: begin
                case (r_op)
                    OP_PUSH: w_next = STATE_STACK_REG;
                    OP_POP:  w_next = STATE_SET_REG;
                    OP_CALL: w_next = STATE_STORE_PC;
                    default: w_next = STATE_RET;
                endcase
            end
            STATE_INC_SP:   w_next = STATE_FETCH_SP;
            STATE_STORE_PC: w_next = STATE_TMP_JUMP;
            STATE_WAIT:     if (step) w_next = STATE_FETCH_PC;
            STATE_HALT:     w_next = STATE_HALT;
            default:        w_last = 1'b1;
        endcase
        if (w_last) begin
            w_next      = step_mode ? STATE_WAIT : STATE_FETCH_PC;
            w_exec_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= STATE_FETCH_PC;
            r_op      <= OP_NOP;
            r_exec    <= 1'b0;
            r_op1     <= 3'd0;
            r_op2     <= 3'd0;
            r_illegal <= 1'b0;
        end else if (!hold) begin
            r_state <= w_next;
            r_exec  <= w_exec_next;
            if (r_state == STATE_DECODE) begin
                r_op  <= op_kind_e'(w_kind);
                r_op1 <= instr[5:3];
                r_op2 <= instr[2:0];
                if (w_dec_illegal) r_illegal <= 1'b1;
            end
        end
    end

    assign state      = r_state;
    assign operand1   = r_op1;
    assign operand2   = r_op2;
    assign instr_done = w_last & ~hold;
    assign halted     = (r_state == STATE_HALT);
    assign illegal    = r_illegal;

endmodule

// File: tb/tb_sequencer.sv
// Self-checking bench for sequencer: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based reference model.
module tb_sequencer;
    import sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] instr = 8'h00;
    logic       hold = 1'b0;
    logic       step_mode = 1'b0;
    logic       step = 1'b0;
    logic [7:0] state;
    logic [2:0] operand1, operand2;
    logic       instr_done, halted, illegal;

    sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .instr      (instr),
        .hold       (hold),
        .step_mode  (step_mode),
        .step       (step),
        .state      (state),
        .operand1   (operand1),
        .operand2   (operand2),
        .instr_done (instr_done),
        .halted     (halted),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_done = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: current state plus the queue of states still to visit.
    logic [7:0] m_state;
    logic [7:0] m_pend[$];
    logic [2:0] m_o1, m_o2;
    logic       m_ill;

    logic [7:0] s_state;
    logic [2:0] s_o1, s_o2;
    logic       s_done, s_ill, s_halted;

    function automatic bit is_nop(input logic [7:0] i);
        return (i[7:6] == 2'b11) && (i[5:3] == 3'b011);
    endfunction

    task automatic expand(input logic [7:0] i);
        m_pend = {};
        case (i[7:6])
            2'b00: m_pend = {STATE_ALU_EXEC, STATE_ALU_OUT};
            2'b01: m_pend = {STATE_MOV_REG};
            2'b10: begin
                case (i[2:0])
                    3'd0: m_pend = {STATE_FETCH_PC, STATE_SET_REG};
                    3'd1: m_pend = {STATE_FETCH_PC, STATE_LOAD_ADDR, STATE_SET_REG};
                    3'd2: m_pend = {STATE_FETCH_PC, STATE_LOAD_ADDR, STATE_SET_MEM};
                    3'd3: m_pend = {STATE_FETCH_SP, STATE_STACK_REG};
                    3'd4: m_pend = {STATE_INC_SP, STATE_FETCH_SP, STATE_SET_REG};
                    default: begin m_ill = 1'b1; m_pend = {STATE_HALT}; end
                endcase
            end
            default: begin
                case (i[5:3])
                    3'd0: m_pend = {STATE_FETCH_PC, STATE_SET_MAR, STATE_JUMP};
                    3'd1: m_pend = {STATE_FETCH_PC, STATE_SET_MAR, STATE_FETCH_SP,
                                    STATE_STORE_PC, STATE_TMP_JUMP};
                    3'd2: m_pend = {STATE_INC_SP, STATE_FETCH_SP, STATE_RET};
                    3'd3: m_pend = {};
                    3'd7: m_pend = {STATE_HALT};
                    default: begin m_ill = 1'b1; m_pend = {STATE_HALT}; end
                endcase
            end
        endcase
    endtask

    task automatic model_reset();
        m_state = STATE_FETCH_PC;
        m_pend  = {STATE_FETCH_INST, STATE_DECODE};
        m_o1 = 3'd0; m_o2 = 3'd0; m_ill = 1'b0;
    endtask

    task automatic model_step();
        if (m_state == STATE_HALT || hold) return;
        if (m_state == STATE_WAIT) begin
            if (step) begin
                m_state = STATE_FETCH_PC;
                m_pend  = {STATE_FETCH_INST, STATE_DECODE};
            end
            return;
        end
        if (m_state == STATE_DECODE) begin
            m_o1 = instr[5:3];
            m_o2 = instr[2:0];
            expand(instr);
        end
        if (m_pend.size() > 0) begin
            m_state = m_pend.pop_front();
        end else if (step_mode) begin
            m_state = STATE_WAIT;
        end else begin
            m_state = STATE_FETCH_PC;
            m_pend  = {STATE_FETCH_INST, STATE_DECODE};
        end
    endtask

    function automatic logic model_done();
        if (hold) return 1'b0;
        if (m_state == STATE_DECODE) return is_nop(instr);
        return (m_pend.size() == 0) && (m_state != STATE_WAIT) && (m_state != STATE_HALT);
    endfunction

    task automatic compare_all();
        s_state = state; s_o1 = operand1; s_o2 = operand2;
        s_done = instr_done; s_ill = illegal; s_halted = halted;
        if (instr_done) n_done++;
        check("state",      32'(state),      32'(m_state));
        check("operand1",   32'(operand1),   32'(m_o1));
        check("operand2",   32'(operand2),   32'(m_o2));
        check("instr_done", 32'(instr_done), 32'(model_done()));
        check("halted",     32'(halted),     32'(m_state == STATE_HALT));
        check("illegal",    32'(illegal),    32'(m_ill));
    endtask

    // Inputs are driven 1 time unit after a rising edge; outputs sampled 1 unit later.
    task automatic tick();
        #1;
        compare_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check("rst_state",   32'(state),      32'(STATE_FETCH_PC));
        check("rst_done",    32'(instr_done), 32'(0));
        check("rst_illegal", 32'(illegal),    32'(0));
        check("rst_ops",     32'({operand1, operand2}), 32'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    function automatic logic [7:0] rand_instr();
        logic [7:0] i;
        i = 8'($urandom);
        if ($urandom_range(0, 19) == 0) return i;
        case ($urandom_range(0, 3))
            0: i[7:6] = 2'b00;
            1: i[7:6] = 2'b01;
            2: begin i[7:6] = 2'b10; i[2:0] = 3'($urandom_range(0, 4)); end
            default: begin
                i[7:6] = 2'b11;
                case ($urandom_range(0, 9))
                    0, 1, 2: i[5:3] = 3'd0;
                    3, 4:    i[5:3] = 3'd1;
                    5, 6:    i[5:3] = 3'd2;
                    7, 8:    i[5:3] = 3'd3;
                    default: i[5:3] = 3'd7;
                endcase
            end
        endcase
        return i;
    endfunction

    logic [7:0] alu_seq[6];
    int halt_cycles;

    initial begin
        alu_seq = '{STATE_FETCH_PC, STATE_FETCH_INST, STATE_DECODE,
                    STATE_ALU_EXEC, STATE_ALU_OUT, STATE_FETCH_PC};
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 32'(state), 32'(STATE_FETCH_PC));
        reset = 1'b0;

        // ALU instruction straight after reset
        instr = 8'b00_001_010;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("alu_seq", 32'(s_state), 32'(alu_seq[k]));
            if (k == 4) check("alu_done", 32'(s_done), 32'(1));
        end
        check("alu_op1", 32'(s_o1), 32'(1));
        check("alu_op2", 32'(s_o2), 32'(2));

        // CALL with a 3-cycle stall in FETCH_SP
        instr = 8'b11_001_000;
        n_done = 0;
        repeat (4) tick();
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("call_hold", 32'(s_state), 32'(STATE_FETCH_SP));
        end
        hold = 1'b0;
        tick(); check("call_sp4",  32'(s_state), 32'(STATE_FETCH_SP));
        tick(); check("call_spc",  32'(s_state), 32'(STATE_STORE_PC));
        tick(); check("call_tmpj", 32'(s_state), 32'(STATE_TMP_JUMP));
        check("call_done_count", 32'(n_done), 32'(1));

        // MOV in step mode, then a long WAIT released by one step pulse
        step_mode = 1'b1;
        instr = 8'b01_011_100;
        repeat (3) tick();
        tick(); check("mov_reg", 32'(s_state), 32'(STATE_MOV_REG));
        for (int k = 0; k < 10; k++) begin
            tick();
            check("wait_hold", 32'(s_state), 32'(STATE_WAIT));
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        step_mode = 1'b0;
        tick(); check("step_release", 32'(s_state), 32'(STATE_FETCH_PC));

        // Illegal memory subop: DECODE then absorbing HALT
        instr = 8'b10_000_111;
        tick();
        tick(); check("ill_decode", 32'(s_state), 32'(STATE_DECODE));
        tick(); check("ill_halt",   32'(s_state), 32'(STATE_HALT));
        check("ill_flag", 32'(s_ill),    32'(1));
        check("ill_hltd", 32'(s_halted), 32'(1));
        step = 1'b1; hold = 1'b1; instr = 8'h00;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("halt_absorb", 32'(s_state), 32'(STATE_HALT));
            step = ~step; hold = 1'($urandom);
        end
        step = 1'b0; hold = 1'b0;

        // Reset in the middle of a POP
        do_reset();
        instr = 8'b10_000_100;
        repeat (4) tick();
        check("pop_in_sp", 32'(state), 32'(STATE_FETCH_SP));
        n_done = 0;
        do_reset();
        check("pop_no_done", 32'(n_done), 32'(0));

        // Randomized traffic
        halt_cycles = 0;
        for (int c = 0; c < 3000; c++) begin
            instr = rand_instr();
            hold  = ($urandom_range(0, 9) < 2);
            step  = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 39) == 0) step_mode = ~step_mode;
            if (m_state == STATE_HALT) halt_cycles++;
            if (halt_cycles > 3 || $urandom_range(0, 299) == 0) begin
                halt_cycles = 0;
                do_reset();
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
